// File: rtl/reg_loader.sv
// Byte-stream to bank loader: packs byte pairs (high first) into words written to consecutive registers; 3 cycles/word (4 with verify).
// Stalls in HI/LO while in_valid is low (in_ready only in HI/LO); optional read-back check under REG_LOADER_VERIFY_EN.
module reg_loader #(
  parameter int NUM_REGS = 14,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] addr_rd,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HI     = 3'd1,
    LO     = 3'd2,
    WRITE  = 3'd3,
    VERIFY = 3'd4,
    FIN    = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   N_REGS    = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] addr_wr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              err_q;
  logic              args_bad;
  logic              last_word;

  assign args_bad  = ({1'b0, base_addr} >= N_REGS) || ({1'b0, count} > N_REGS);
  assign last_word = (remaining == ADDR_W'(1));

  assign addr_wr = addr_wr_q;
  assign wr_data = wr_data_q;
  assign err     = err_q;

`ifdef REG_LOADER_VERIFY_EN
  assign addr_rd = cur_addr;
`else
  logic unused_rd;
  assign unused_rd = ^rd_data;
  assign addr_rd   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    we        = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          if (args_bad || count == '0) state_nxt = FIN;
          else                         state_nxt = HI;
        end
      end
      HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LO;
      end
      LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = WRITE;
      end
      WRITE: begin
        we = 1'b1;
`ifdef REG_LOADER_VERIFY_EN
        state_nxt = VERIFY;
`else
        state_nxt = last_word ? FIN : HI;
`endif
      end
      VERIFY: begin
        state_nxt = last_word ? FIN : HI;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write port registers are loaded on the LO handshake so they are valid during WRITE and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      word      <= '0;
      addr_wr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_q <= args_bad;
            if (!args_bad && count != '0) begin
              cur_addr  <= base_addr;
              remaining <= count;
            end
          end
        end
        HI: begin
          if (in_valid) word[DATA_W-1 -: 8] <= in_data;
        end
        LO: begin
          if (in_valid) begin
            word[7:0] <= in_data;
            addr_wr_q <= cur_addr;
            wr_data_q <= {word[DATA_W-1 -: 8], in_data};
          end
        end
`ifndef REG_LOADER_VERIFY_EN
        WRITE: begin
          cur_addr  <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
        end
`endif
        VERIFY: begin
          if (rd_data != word) err_q <= 1'b1;
          cur_addr  <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/reg_loader.md
# reg_loader

Sequential write-side master for the 14×16 register bank. It accepts a byte stream over a valid/ready handshake and packs each pair of bytes, high byte first, into a 16-bit word. It writes each word into consecutive bank registers starting at a programmed base address. It sits between a byte source (UART/host bridge) and the bank's write port, and optionally uses one bank read port to check each write.

## Interface
- `NUM_REGS`, 14, number of bank registers (valid addresses 0..NUM_REGS-1)
- `ADDR_W`, 4, register address width
- `DATA_W`, 16, register width (two bytes)
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  single-cycle request to begin a load session
- `base_addr`  in  ADDR_W  first register to write; sampled with `start`
- `count`  in  ADDR_W  number of words to write; sampled with `start`
- `in_valid`  in  1  byte source has data
- `in_data`  in  8  byte from source
- `in_ready`  out  1  loader accepts a byte this cycle
- `we`  out  1  bank write enable
- `addr_wr`  out  ADDR_W  bank write address
- `wr_data`  out  DATA_W  bank write data
- `addr_rd`  out  ADDR_W  bank read address (verify)
- `rd_data`  in  DATA_W  bank read data (asynchronous read)
- `busy`  out  1  session in progress
- `done`  out  1  one-cycle pulse at session end
- `err`  out  1  sticky error; cleared by the next accepted `start`

## Operation
- **States:** IDLE, HI, LO, WRITE, VERIFY, FIN.
- **IDLE:**
  - `start` with `base_addr < NUM_REGS`, `1 <= count <= NUM_REGS`: latch `cur_addr=base_addr` and `remaining=count`, clear `err`, go to HI.
  - `start` with `count==0`: clear `err`, go to FIN with no writes.
  - `start` with `base_addr >= NUM_REGS` or `count > NUM_REGS`: set `err`, go to FIN with no writes.
- **HI:** `in_ready=1`. A handshake (`in_valid & in_ready`) latches `in_data` into `word[15:8]`, then go to LO.
- **LO:** `in_ready=1`. A handshake latches `word[7:0]`, then go to WRITE.
- **WRITE:**
  - Drives `we=1`, `addr_wr=cur_addr`, `wr_data=word` for exactly one cycle.
  - Next state is VERIFY if compiled in, else the advance step.
- **VERIFY:** drives `addr_rd=cur_addr`. If `rd_data != word`, set `err`. Then do the advance step.
- **Advance step:**
  - `cur_addr` increments, wrapping from NUM_REGS-1 to 0.
  - `remaining` decrements. If it reaches 0 go to FIN, else go to HI.
- **FIN:** `done=1` for one cycle, then IDLE.
- **busy:** 1 in every state except IDLE.
- **start outside IDLE:** ignored.
- **Other outputs:**
  - `we` is 0 outside WRITE.
  - `in_ready` is 0 outside HI and LO.
  - `addr_wr` and `wr_data` hold their last values.
- **Unconsumed input:** bytes are never dropped or duplicated. The source holds `in_data` while `in_valid & !in_ready`.
- **Reset values:** `in_ready=0`, `we=0`, `addr_wr=0`, `wr_data=0`, `addr_rd=0`, `busy=0`, `done=0`, `err=0`, state IDLE.
- **Reset mid-session:** the reset edge forces IDLE and `we=0`. The partial word is discarded and no `done` pulse is issued.

## Timing
- `start` is sampled at edge N. `in_ready` rises after edge N; with back-to-back `in_valid`, the first byte is accepted at edge N+1.
- The word write occurs at the edge ending the WRITE cycle. That is the 3rd cycle after the word's high byte is offered, with no stalls.
- VERIFY compares in the cycle after the bank edge, using the bank's asynchronous read.
- Best-case throughput: 3 cycles/word, or 4 with verify.
- Session of k words, no stalls: `done` is high in cycle 1+3k (or 1+4k) after the start edge.
- `in_valid` low stalls HI/LO indefinitely with no timeout. Outputs are stable while stalled.

## Configuration
- `REG_LOADER_VERIFY_EN` defined:
  - The VERIFY state exists and `addr_rd` follows `cur_addr`.
  - A read-back mismatch sets `err`.
- Not defined:
  - VERIFY is skipped, `addr_rd` is tied to 0, and `rd_data` is ignored.
  - `err` is set only by bad `start` arguments.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs 0, state IDLE; hold `in_valid=1` → `in_ready` stays 0.
- **Three-word load:** `start`, `base_addr=2`, `count=3`, bytes 12 34 AB CD 00 FF back-to-back → bank R2=0x1234, R3=0xABCD, R4=0x00FF. Exactly 3 `we` pulses; `done` at cycle 10 (13 with verify); `err=0`.
- **Wrap-around:** `base_addr=13`, `count=2`, bytes 11 11 22 22 → R13=0x1111, R0=0x2222.
- **Bad arguments:** `start` with `base_addr=14`, `count=1` → no `we`, `err=1`, `done` pulse one cycle later. A following valid `start` clears `err`.
- **Stall and reset:**
  - Deassert `in_valid` for 5 cycles between the HI and LO bytes → write is delayed by 5 cycles with correct data.
  - Assert `rst` while in LO → no write, `busy=0` the next cycle.
- **Verify (macro on):** testbench forces the bank to return `rd_data=0xDEAD` against written 0x1234 → `err=1`, the session still completes, `done` pulses.
